hiscore_ram_port: RTL and testbench
===================================

Name: hiscore_ram_port

Overview:
- Responder end of the hiscore RAM-access protocol (hs_address / hs_data_in / hs_write / hs_access).
- Sits inside the game core in front of the single-port work RAM.
- Halts the CPU, hands the RAM port to the hiscore engine, returns read data, then gives the RAM back to the CPU.
- Replaces the bare "pause = hs_access | user pause" coupling with a proper grant handshake.

Parameters:
- ADDR_W, 12, RAM and hiscore address width.
- DATA_W, 8, data width.
- IDLE_CYCLES, 2, consecutive cpu_idle cycles required before the grant.
- HALT_TIMEOUT, 1024, maximum cycles in HALT_REQ before a forced grant; 0 disables the timeout.
- GUARD_CYCLES, 2, cycles the hiscore side keeps ownership, with writes blocked, after release.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- hs_access  in  1  hiscore requests the RAM
- hs_address  in  ADDR_W  hiscore address
- hs_data_in  in  DATA_W  hiscore write data
- hs_write  in  1  hiscore write strobe
- hs_data_out  out  DATA_W  registered read data to hiscore
- hs_grant  out  1  hiscore owns the RAM port
- user_pause  in  1  user pause request, passed through
- cpu_idle  in  1  CPU is at a safe stop point under pause
- cpu_pause  out  1  CPU halt request
- cpu_addr  in  ADDR_W  CPU address
- cpu_dout  in  DATA_W  CPU write data
- cpu_we  in  1  CPU write strobe (qualified by cpu_cs)
- cpu_cs  in  1  CPU selects work RAM
- cpu_din  out  DATA_W  RAM read data to CPU
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_dout  in  DATA_W  RAM read data, synchronous RAM with 1-cycle latency
- timeout_flag  out  1  sticky: a grant was forced by timeout

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- States: IDLE, HALT_REQ, HS_OWN, DRAIN. Reset puts the FSM in IDLE.
- Reset values of outputs: hs_grant=0, cpu_pause=user_pause (combinational pass-through), ram_we=0, hs_data_out=0, cpu_din=0, timeout_flag=0.
- IDLE:
  - RAM port muxed to the CPU: ram_addr=cpu_addr, ram_din=cpu_dout, ram_we=cpu_we&cpu_cs.
  - cpu_din <= ram_dout every cycle, so CPU read data is valid 2 cycles after the address.
  - hs_access=1 -> HALT_REQ.
- HALT_REQ:
  - Asserts cpu_pause. RAM stays on the CPU mux, but ram_we is forced to 0.
  - Counts consecutive cpu_idle cycles; the count resets when cpu_idle=0.
  - Count reaches IDLE_CYCLES -> HS_OWN.
  - Wait counter reaches HALT_TIMEOUT (if nonzero) -> HS_OWN, and timeout_flag set to 1.
  - hs_access drops -> IDLE; cpu_pause deasserts the next cycle unless user_pause=1.
- HS_OWN:
  - hs_grant=1, cpu_pause=1.
  - ram_addr=hs_address, ram_din=hs_data_in, ram_we=hs_write.
  - hs_data_out <= ram_dout every cycle, giving 2-cycle read latency from hs_address.
  - cpu_din holds its last value.
  - hs_access drops -> DRAIN.
- DRAIN:
  - Ownership and mux stay on the hiscore side, ram_we=0, cpu_pause=1 for GUARD_CYCLES cycles, then -> IDLE.
  - hs_grant falls on the first DRAIN cycle.
  - hs_access reasserting during DRAIN -> HS_OWN directly, with no new halt handshake.
- cpu_pause = user_pause | (state != IDLE). user_pause never blocks or delays the FSM.
- A CPU write attempted outside IDLE is dropped, never deferred.
- hs_write with hs_access=0 is ignored in every state.
- Counters saturate and never wrap. Counter widths come from clog2 of the parameter, minimum 1.
- Reset mid-operation: the next cycle is IDLE with ram_we=0 and hs_grant=0. An in-flight hiscore write is abandoned. timeout_flag is cleared.

Decomposition:
- Package hiscore_pkg: state enum (IDLE, HALT_REQ, HS_OWN, DRAIN), default widths ADDR_W/DATA_W, counter-width function.
- One sub-module, hiscore_port_mux: registered-free 2:1 RAM port mux with write gating, selected by the owner bit and a write-block bit.
- FSM, counters and read registers live in the top.

Test Plan:
- Grant path: cpu_idle held 1, hs_access rises at cycle 0 -> cpu_pause=1 at cycle 1; hs_grant=1 at cycle 3 (IDLE_CYCLES=2); CPU write to 0x100 during HALT_REQ leaves RAM unchanged.
- Hiscore read/write: in HS_OWN, write 0x5A at 0x2F0, then read 0x2F0 -> hs_data_out=0x5A exactly 2 cycles after the read address; ram_we never high in DRAIN.
- Timeout: cpu_idle held 0, HALT_TIMEOUT=16 -> hs_grant rises on cycle 17 after the request; timeout_flag=1 and stays 1 after release until reset.
- Abort and re-entry:
  - hs_access dropped during HALT_REQ -> IDLE; cpu_pause=0 the next cycle with user_pause=0.
  - hs_access re-raised during DRAIN -> HS_OWN the next cycle, with no cpu_idle wait.
- Pause and reset interaction:
  - user_pause=1 with no request -> cpu_pause=1 and FSM stays IDLE.
  - Reset during HS_OWN with hs_write=1 -> next cycle ram_we=0, hs_grant=0, state IDLE.

Source files
------------

// File: rtl/hiscore_pkg.sv
// Shared types and sizing helpers for the hiscore RAM-access responder.
package hiscore_pkg;

  localparam int HS_ADDR_W = 12;
  localparam int HS_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    HALT_REQ,
    HS_OWN,
    DRAIN
  } hs_state_e;

  // Counter width for a terminal count n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hiscore_port_mux.sv
// Combinational 2:1 RAM port mux: CPU or hiscore side, with a write-block override.
module hiscore_port_mux
  import hiscore_pkg::*;
#(
  parameter int ADDR_W = HS_ADDR_W,
  parameter int DATA_W = HS_DATA_W
) (
  input  logic              owner_hs,
  input  logic              wr_block,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] hs_addr,
  input  logic [DATA_W-1:0] hs_din,
  input  logic              hs_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we
);

  assign ram_addr = owner_hs ? hs_addr : cpu_addr;
  assign ram_din  = owner_hs ? hs_din  : cpu_dout;
  assign ram_we   = !wr_block && (owner_hs ? hs_wr : cpu_wr);

endmodule

// File: rtl/hiscore_ram_port.sv
// Hiscore RAM-access responder: halts the CPU, grants the work-RAM port to the
// hiscore engine, returns read data, then hands the port back after a guard time.
module hiscore_ram_port
  import hiscore_pkg::*;
#(
  parameter int ADDR_W       = HS_ADDR_W,
  parameter int DATA_W       = HS_DATA_W,
  parameter int IDLE_CYCLES  = 2,
  parameter int HALT_TIMEOUT = 1024,
  parameter int GUARD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hs_access,
  input  logic [ADDR_W-1:0] hs_address,
  input  logic [DATA_W-1:0] hs_data_in,
  input  logic              hs_write,
  output logic [DATA_W-1:0] hs_data_out,
  output logic              hs_grant,
  input  logic              user_pause,
  input  logic              cpu_idle,
  output logic              cpu_pause,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_we,
  input  logic              cpu_cs,
  output logic [DATA_W-1:0] cpu_din,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              timeout_flag
);

  localparam int IW = cnt_w(IDLE_CYCLES);
  localparam int TW = cnt_w(HALT_TIMEOUT);
  localparam int GW = cnt_w(GUARD_CYCLES);

  hs_state_e       state, state_nx;
  logic [IW-1:0]   idle_cnt, idle_cnt_nx;
  logic [TW-1:0]   wait_cnt, wait_cnt_nx;
  logic [GW-1:0]   guard_cnt, guard_cnt_nx;
  logic            force_grant;
  logic            idle_done, wait_done, guard_done;
  logic            owner_hs, wr_block;

  // Terminal tests look one count ahead so the transition lands on the Nth cycle.
  assign idle_done  = cpu_idle && ((int'(idle_cnt) + 1) >= IDLE_CYCLES);
  assign wait_done  = (HALT_TIMEOUT != 0) && ((int'(wait_cnt) + 1) >= HALT_TIMEOUT);
  assign guard_done = (int'(guard_cnt) + 1) >= GUARD_CYCLES;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idle_cnt     <= '0;
      wait_cnt     <= '0;
      guard_cnt    <= '0;
      timeout_flag <= 1'b0;
      hs_data_out  <= '0;
      cpu_din      <= '0;
    end else begin
      state        <= state_nx;
      idle_cnt     <= idle_cnt_nx;
      wait_cnt     <= wait_cnt_nx;
      guard_cnt    <= guard_cnt_nx;
      timeout_flag <= timeout_flag | force_grant;
      if (state == IDLE)   cpu_din     <= ram_dout;
      if (state == HS_OWN) hs_data_out <= ram_dout;
    end
  end

  always_comb begin
    state_nx     = state;
    idle_cnt_nx  = '0;
    wait_cnt_nx  = '0;
    guard_cnt_nx = '0;
    force_grant  = 1'b0;
    case (state)
      IDLE: if (hs_access) state_nx = HALT_REQ;
      HALT_REQ: begin
        if (!hs_access) state_nx = IDLE;
        else if (idle_done) state_nx = HS_OWN;
        else if (wait_done) begin
          state_nx    = HS_OWN;
          force_grant = 1'b1;
        end else begin
          idle_cnt_nx = !cpu_idle ? '0 : ((&idle_cnt) ? idle_cnt : idle_cnt + 1'b1);
          wait_cnt_nx = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;
        end
      end
      HS_OWN: if (!hs_access) state_nx = DRAIN;
      DRAIN: begin
        // A fresh request inside the guard window skips the halt handshake.
        if (hs_access) state_nx = HS_OWN;
        else if (guard_done) state_nx = IDLE;
        else guard_cnt_nx = (&guard_cnt) ? guard_cnt : guard_cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign hs_grant  = (state == HS_OWN);
  assign cpu_pause = user_pause | (state != IDLE);
  assign owner_hs  = (state == HS_OWN) || (state == DRAIN);
  // Reset also blocks writes so an in-flight hiscore write is abandoned.
  assign wr_block  = reset || (state == HALT_REQ) || (state == DRAIN);

  hiscore_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .owner_hs (owner_hs),
    .wr_block (wr_block),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_wr   (cpu_we & cpu_cs),
    .hs_addr  (hs_address),
    .hs_din   (hs_data_in),
    .hs_wr    (hs_write & hs_access),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we)
  );

endmodule

// File: tb/tb_hiscore_ram_port.sv
// Bench for hiscore_ram_port: directed protocol scenarios plus randomized traffic
// against a cycle-level reference of the access protocol and a shadow memory.
module tb_hiscore_ram_port;

  localparam int AW = 12, DW = 8, IDLE_N = 2, TMO = 16, GUARD_N = 2;
  localparam int M_FREE = 0, M_HALT = 1, M_OWN = 2, M_GUARD = 3;

  logic          clk = 1'b0;
  logic          reset, hs_access, hs_write, hs_grant, user_pause, cpu_idle, cpu_pause;
  logic          cpu_we, cpu_cs, ram_we, timeout_flag, ram_clr;
  logic [AW-1:0] hs_address, cpu_addr, ram_addr;
  logic [DW-1:0] hs_data_in, hs_data_out, cpu_dout, cpu_din, ram_din, ram_dout;

  always #5 clk = ~clk;

  hiscore_ram_port #(
    .ADDR_W(AW), .DATA_W(DW), .IDLE_CYCLES(IDLE_N), .HALT_TIMEOUT(TMO), .GUARD_CYCLES(GUARD_N)
  ) dut (
    .clk(clk), .reset(reset), .hs_access(hs_access), .hs_address(hs_address),
    .hs_data_in(hs_data_in), .hs_write(hs_write), .hs_data_out(hs_data_out),
    .hs_grant(hs_grant), .user_pause(user_pause), .cpu_idle(cpu_idle),
    .cpu_pause(cpu_pause), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
    .cpu_cs(cpu_cs), .cpu_din(cpu_din), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout), .timeout_flag(timeout_flag)
  );

  // Work RAM: synchronous, one cycle read latency, read-old on collision.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= '0;
      ram_dout <= '0;
    end else begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
    end
  end

  // Reference state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_mode, idle_run, wait_age, guard_age;
  logic          m_tflag;
  logic [DW-1:0] m_cpu_din, m_hs_dout, m_ram_q;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Evaluate one cycle of the reference at the negedge, then advance it.
  task automatic model_cycle();
    logic          e_own, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, nq;
    e_own  = (m_mode == M_OWN) || (m_mode == M_GUARD);
    e_addr = e_own ? hs_address : cpu_addr;
    e_din  = e_own ? hs_data_in : cpu_dout;
    e_we   = (m_mode == M_FREE && cpu_we && cpu_cs) || (m_mode == M_OWN && hs_access && hs_write);
    if (!reset) begin
      chk("grant",    32'(hs_grant),     32'(m_mode == M_OWN));
      chk("cpu_pause",32'(cpu_pause),    32'(user_pause || m_mode != M_FREE));
      chk("ram_we",   32'(ram_we),       32'(e_we));
      chk("ram_addr", 32'(ram_addr),     32'(e_addr));
      if (e_we) chk("ram_din", 32'(ram_din), 32'(e_din));
      chk("hs_dout",  32'(hs_data_out),  32'(m_hs_dout));
      chk("cpu_din",  32'(cpu_din),      32'(m_cpu_din));
      chk("tflag",    32'(timeout_flag), 32'(m_tflag));
    end
    nq = ref_mem[e_addr];
    if (ram_clr) begin
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
      nq = '0;
    end
    if (reset) begin
      m_mode = M_FREE; m_tflag = 1'b0; m_cpu_din = '0; m_hs_dout = '0; m_ram_q = nq;
    end else begin
      if (e_we) ref_mem[e_addr] = e_din;
      if (m_mode == M_FREE) m_cpu_din = m_ram_q;
      if (m_mode == M_OWN)  m_hs_dout = m_ram_q;
      m_ram_q = nq;
      case (m_mode)
        M_FREE: if (hs_access) begin m_mode = M_HALT; idle_run = 0; wait_age = 0; end
        M_HALT: begin
          idle_run = cpu_idle ? idle_run + 1 : 0;
          wait_age = wait_age + 1;
          if (!hs_access) m_mode = M_FREE;
          else if (idle_run >= IDLE_N) m_mode = M_OWN;
          else if (TMO != 0 && wait_age >= TMO) begin m_mode = M_OWN; m_tflag = 1'b1; end
        end
        M_OWN: if (!hs_access) begin m_mode = M_GUARD; guard_age = 0; end
        default: begin
          guard_age = guard_age + 1;
          if (hs_access) m_mode = M_OWN;
          else if (guard_age >= GUARD_N) m_mode = M_FREE;
        end
      endcase
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; ram_clr = 1; hs_access = 0; hs_write = 0; hs_address = '0; hs_data_in = '0;
    user_pause = 0; cpu_idle = 0; cpu_addr = '0; cpu_dout = '0; cpu_we = 0; cpu_cs = 0;
    m_mode = M_FREE; m_tflag = 0; m_cpu_din = '0; m_hs_dout = '0; m_ram_q = '0;
    idle_run = 0; wait_age = 0; guard_age = 0;
    step(); step();
    reset = 0; ram_clr = 0;
    chk("rst_grant", 32'(hs_grant), 0);
    chk("rst_we",    32'(ram_we), 0);
    chk("rst_hsd",   32'(hs_data_out), 0);
    chk("rst_cpud",  32'(cpu_din), 0);
    chk("rst_tflag", 32'(timeout_flag), 0);

    // user pause alone: pass-through, no grant
    user_pause = 1; #1;
    chk("upause_on", 32'(cpu_pause), 1);
    repeat (3) step();
    chk("upause_nogrant", 32'(hs_grant), 0);
    user_pause = 0; #1;
    chk("upause_off", 32'(cpu_pause), 0);

    // CPU write 0x11 at 0x100, then read it back with 2-cycle latency
    cpu_addr = 12'h100; cpu_dout = 8'h11; cpu_we = 1; cpu_cs = 1; #1;
    chk("cpu_we", 32'(ram_we), 1);
    step(); cpu_we = 0;
    step(); step();
    chk("cpu_rd", 32'(cpu_din), 32'h11);
    cpu_cs = 0;

    // grant path, CPU write during HALT_REQ dropped
    cpu_idle = 1; hs_access = 1; hs_address = 12'h2F0;
    step();
    chk("c1_pause", 32'(cpu_pause), 1);
    chk("c1_grant", 32'(hs_grant), 0);
    cpu_addr = 12'h100; cpu_dout = 8'hAB; cpu_we = 1; cpu_cs = 1; #1;
    chk("halt_we", 32'(ram_we), 0);
    step();
    chk("c2_grant", 32'(hs_grant), 0);
    step();
    chk("c3_grant", 32'(hs_grant), 1);
    cpu_we = 0; cpu_cs = 0;

    // hiscore write 0x5A @0x2F0, read back at exactly 2 cycles
    hs_data_in = 8'h5A; hs_write = 1; #1;
    chk("hs_we", 32'(ram_we), 1);
    step(); hs_write = 0;
    step();
    chk("hs_rd_early", 32'(hs_data_out), 0);
    step();
    chk("hs_rd", 32'(hs_data_out), 32'h5A);
    hs_address = 12'h100;
    step(); step();
    chk("cpu_wr_dropped", 32'(hs_data_out), 32'h11);

    // release: hs_write with hs_access low ignored, no writes in DRAIN
    hs_access = 0; hs_write = 1; #1;
    chk("wr_noaccess", 32'(ram_we), 0);
    step();
    chk("drain_grant", 32'(hs_grant), 0);
    chk("drain1_we", 32'(ram_we), 0);
    chk("drain_pause", 32'(cpu_pause), 1);
    step();
    chk("drain2_we", 32'(ram_we), 0);
    step(); hs_write = 0;
    chk("back_idle", 32'(cpu_pause), 0);

    // timeout path
    cpu_idle = 0; hs_access = 1;
    repeat (16) step();
    chk("tmo_c16", 32'(hs_grant), 0);
    chk("tmo_c16_flag", 32'(timeout_flag), 0);
    step();
    chk("tmo_c17", 32'(hs_grant), 1);
    chk("tmo_flag", 32'(timeout_flag), 1);
    hs_access = 0;
    repeat (4) step();
    chk("tmo_sticky", 32'(timeout_flag), 1);

    // abort during HALT_REQ
    hs_access = 1; step();
    chk("abort_halt", 32'(cpu_pause), 1);
    hs_access = 0; step();
    chk("abort_pause", 32'(cpu_pause), 0);

    // re-entry from DRAIN without a cpu_idle wait
    cpu_idle = 1; hs_access = 1;
    repeat (3) step();
    chk("re_grant", 32'(hs_grant), 1);
    hs_access = 0; cpu_idle = 0; step();
    chk("re_drain", 32'(hs_grant), 0);
    hs_access = 1; step();
    chk("reentry", 32'(hs_grant), 1);

    // reset during HS_OWN with an active write
    hs_write = 1; hs_address = 12'h3C0; hs_data_in = 8'hEE; reset = 1;
    step(); reset = 0;
    chk("mid_rst_we", 32'(ram_we), 0);
    chk("mid_rst_grant", 32'(hs_grant), 0);
    chk("mid_rst_pause", 32'(cpu_pause), 0);
    chk("mid_rst_tflag", 32'(timeout_flag), 0);
    hs_access = 0; hs_write = 0;
    step();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) hs_access = ~hs_access;
      hs_write   = ($urandom_range(0, 2) == 0);
      hs_address = 12'h300 | 12'($urandom_range(0, 15));
      hs_data_in = 8'($urandom);
      cpu_addr   = 12'h300 | 12'($urandom_range(0, 15));
      cpu_dout   = 8'($urandom);
      cpu_we     = $urandom_range(0, 1) == 1;
      cpu_cs     = $urandom_range(0, 1) == 1;
      cpu_idle   = (i < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      user_pause = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 0; cpu_we = 0; hs_write = 0;
    step(); step();
    for (int a = 0; a < 16; a++)
      chk("mem", 32'(ram_mem[12'h300 + a]), 32'(ref_mem[12'h300 + a]));
    chk("mem_2f0", 32'(ram_mem[12'h2F0]), 32'(ref_mem[12'h2F0]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
